// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared types and constants for the Common Data Bus producer slice.
//   PREG_BITS    : width of a physical register tag, derived from NUM_PHYS_REGS
//   cdb_entry_t  : one buffered/broadcast result (tag + 32-bit data)
//   *_DFLT       : default build parameters for cdb_arbiter
// -----------------------------------------------------------------------------
package cdb_pkg;

   localparam int NUM_PHYS_REGS  = 64;
   localparam int PREG_BITS      = $clog2(NUM_PHYS_REGS);
   localparam int CDB_WIDTH_DFLT = 4;
   localparam int NUM_SRC_DFLT   = 6;
   localparam int QDEPTH_DFLT    = 2;

   typedef struct packed {
      logic [PREG_BITS-1:0] tag;
      logic [31:0]          data;
   } cdb_entry_t;

   localparam int ENTRY_BITS = $bits(cdb_entry_t);

   // Physical register 0 is never a real destination, so a result tagged 0
   // carries nothing worth broadcasting.
   function automatic logic tag_is_live(input cdb_entry_t e);
      return (e.tag != '0);
   endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
// Per-execution-unit result buffer: circular FIFO of cdb_entry_t.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : synchronous clear, wins over a same-edge push
//   push_i        : write entry_i (caller guarantees not full)
//   entry_i       : result to buffer
//   pop_i         : retire the head entry (caller guarantees not empty)
//   head_o        : current head entry
//   count_o       : registered occupancy
//   empty_o       : occupancy is zero
// -----------------------------------------------------------------------------
module cdb_src_fifo
   import cdb_pkg::*;
#(
   parameter int DEPTH = QDEPTH_DFLT,
   localparam int PTR_BITS = $clog2(DEPTH),
   localparam int CNT_BITS = $clog2(DEPTH + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                flush_i,
   input  logic                push_i,
   input  cdb_entry_t          entry_i,
   input  logic                pop_i,
   output cdb_entry_t          head_o,
   output logic [CNT_BITS-1:0] count_o,
   output logic                empty_o
);

   cdb_entry_t          mem_q [DEPTH];
   logic [PTR_BITS-1:0] head_q, head_d;
   logic [PTR_BITS-1:0] tail_q, tail_d;
   logic [CNT_BITS-1:0] count_q, count_d;

   // Next pointer/occupancy; DEPTH is a power of two so pointers wrap naturally.
   always_comb begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      if (flush_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (push_i) begin
            tail_d = tail_q + PTR_BITS'(1);
         end else begin
            tail_d = tail_q;
         end
         if (pop_i) begin
            head_d = head_q + PTR_BITS'(1);
         end else begin
            head_d = head_q;
         end
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_BITS'(1);
            2'b01:   count_d = count_q - CNT_BITS'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Entry storage; a flushed push is discarded.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (push_i && !flush_i) begin
         mem_q[tail_q] <= entry_i;
      end
   end

   assign head_o  = mem_q[head_q];
   assign count_o = count_q;
   assign empty_o = (count_q == '0);

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Producer end of the Common Data Bus. Buffers results from NUM_SRC execution
// units and broadcasts up to CDB_WIDTH of them per cycle from registered slots.
//   clk, rst         : clock, asynchronous active-low reset
//   flush            : synchronous pipeline flush
//   src_valid/tag/data, src_ready : per-source valid/ready result interface
//   cdb_valid/tag/data            : registered broadcast slots
// -----------------------------------------------------------------------------
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int CDB_WIDTH = CDB_WIDTH_DFLT,
   parameter int NUM_SRC   = NUM_SRC_DFLT,
   parameter int QDEPTH    = QDEPTH_DFLT
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                flush,
   input  logic [NUM_SRC-1:0]                  src_valid,
   input  logic [NUM_SRC-1:0][PREG_BITS-1:0]   src_tag,
   input  logic [NUM_SRC-1:0][31:0]            src_data,
   output logic [NUM_SRC-1:0]                  src_ready,
   output logic [CDB_WIDTH-1:0]                cdb_valid,
   output logic [CDB_WIDTH-1:0][PREG_BITS-1:0] cdb_tag,
   output logic [CDB_WIDTH-1:0][31:0]          cdb_data
);

   localparam int SRC_BITS = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
   localparam int SUM_BITS = SRC_BITS + 1;
   localparam int CNT_BITS = $clog2(QDEPTH + 1);
   localparam int GNT_BITS = $clog2(CDB_WIDTH + 1);

   cdb_entry_t [NUM_SRC-1:0]               in_entry_s;
   cdb_entry_t [NUM_SRC-1:0]               head_s;
   cdb_entry_t [NUM_SRC-1:0]               head_rot_s;
   logic [NUM_SRC-1:0][CNT_BITS-1:0]       count_s;
   logic [NUM_SRC-1:0]                     empty_s, push_s, pop_s, live_s, grant_s;
   logic [NUM_SRC-1:0]                     live_rot_s, grant_rot_s;
   logic [2*NUM_SRC-1:0]                   live_dbl_s, grant_dbl_s;
   logic [2*NUM_SRC*ENTRY_BITS-1:0]        head_dbl_s;
   logic [SRC_BITS-1:0]                    rr_q, rr_d, last_rot_s;
   logic [SUM_BITS-1:0]                    rr_sum_s;
   logic [CDB_WIDTH-1:0]                   slot_valid_d, slot_valid_q;
   cdb_entry_t [CDB_WIDTH-1:0]             slot_d, slot_q;

   for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
      assign src_ready[s]  = (count_s[s] != CNT_BITS'(QDEPTH));
      assign push_s[s]     = src_valid[s] & src_ready[s];
      assign in_entry_s[s] = {src_tag[s], src_data[s]};
      assign live_s[s]     = !empty_s[s] && tag_is_live(head_s[s]);
      // Tag-0 heads retire on their first cycle at the head without a grant.
      assign pop_s[s]      = grant_s[s] | (!empty_s[s] & !tag_is_live(head_s[s]));

      cdb_src_fifo #(.DEPTH(QDEPTH)) u_fifo (
         .clk_i   (clk),
         .rst_ni  (rst),
         .flush_i (flush),
         .push_i  (push_s[s]),
         .entry_i (in_entry_s[s]),
         .pop_i   (pop_s[s]),
         .head_o  (head_s[s]),
         .count_o (count_s[s]),
         .empty_o (empty_s[s])
      );
   end

   // Rotate heads into scan order so position i is source (rr_q + i) mod NUM_SRC.
   assign live_dbl_s = {live_s, live_s} >> rr_q;
   assign live_rot_s = live_dbl_s[NUM_SRC-1:0];
   assign head_dbl_s = {head_s, head_s} >> (rr_q * ENTRY_BITS);
   assign head_rot_s = head_dbl_s[NUM_SRC*ENTRY_BITS-1:0];

   // Rotate scan-order grants back to physical source positions.
   assign grant_dbl_s = {grant_rot_s, grant_rot_s} << rr_q;
   assign grant_s     = grant_dbl_s[2*NUM_SRC-1:NUM_SRC];

   // Scan-order grant: the k-th live head found fills slot k.
   always_comb begin
      logic [GNT_BITS-1:0] gcnt;
      gcnt         = '0;
      grant_rot_s  = '0;
      last_rot_s   = '0;
      slot_valid_d = '0;
      slot_d       = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (live_rot_s[i] && (gcnt != GNT_BITS'(CDB_WIDTH))) begin
            grant_rot_s[i] = 1'b1;
            for (int k = 0; k < CDB_WIDTH; k++) begin
               if (gcnt == GNT_BITS'(k)) begin
                  slot_valid_d[k] = 1'b1;
                  slot_d[k]       = head_rot_s[i];
               end else begin
                  slot_valid_d[k] = slot_valid_d[k];
               end
            end
            gcnt       = gcnt + GNT_BITS'(1);
            last_rot_s = SRC_BITS'(i);
         end else begin
            gcnt = gcnt;
         end
      end
   end

   // Next round-robin start: one past the last granted source.
   always_comb begin
      rr_sum_s = {1'b0, rr_q} + {1'b0, last_rot_s} + SUM_BITS'(1);
      if (flush) begin
         rr_d = '0;
      end else if (|grant_rot_s) begin
         if (rr_sum_s >= SUM_BITS'(NUM_SRC)) begin
            rr_d = SRC_BITS'(rr_sum_s - SUM_BITS'(NUM_SRC));
         end else begin
            rr_d = SRC_BITS'(rr_sum_s);
         end
      end else begin
         rr_d = rr_q;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rr_q <= '0;
      end else begin
         rr_q <= rr_d;
      end
   end

   // Broadcast slot registers, reloaded every edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_valid_q <= '0;
         slot_q       <= '0;
      end else if (flush) begin
         slot_valid_q <= '0;
         slot_q       <= '0;
      end else begin
         slot_valid_q <= slot_valid_d;
         slot_q       <= slot_d;
      end
   end

   assign cdb_valid = slot_valid_q;
   for (genvar k = 0; k < CDB_WIDTH; k++) begin : g_slot
      assign cdb_tag[k]  = slot_q[k].tag;
      assign cdb_data[k] = slot_q[k].data;
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cdb_arbiter
// Directed scenarios plus randomized traffic, checked every cycle against a
// queue-based reference model of the CDB producer.
// -----------------------------------------------------------------------------
module tb_cdb_arbiter;
   import cdb_pkg::*;

   localparam int NS = 6;
   localparam int CW = 4;
   localparam int QD = 2;
   localparam int PB = PREG_BITS;

   logic                  clk;
   logic                  rst;
   logic                  flush;
   logic [NS-1:0]         src_valid;
   logic [NS-1:0][PB-1:0] src_tag;
   logic [NS-1:0][31:0]   src_data;
   logic [NS-1:0]         src_ready;
   logic [CW-1:0]         cdb_valid;
   logic [CW-1:0][PB-1:0] cdb_tag;
   logic [CW-1:0][31:0]   cdb_data;

   int n_cmp = 0;
   int n_err = 0;

   cdb_arbiter #(.CDB_WIDTH(CW), .NUM_SRC(NS), .QDEPTH(QD)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .src_valid (src_valid),
      .src_tag   (src_tag),
      .src_data  (src_data),
      .src_ready (src_ready),
      .cdb_valid (cdb_valid),
      .cdb_tag   (cdb_tag),
      .cdb_data  (cdb_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model state: one queue per source plus the scan start.
   cdb_entry_t            mq [NS][$];
   int                    rr_m;
   logic [CW-1:0]         exp_valid;
   logic [CW-1:0][PB-1:0] exp_tag;
   logic [CW-1:0][31:0]   exp_data;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int s = 0; s < NS; s++) mq[s].delete();
      rr_m      = 0;
      exp_valid = '0;
      exp_tag   = '0;
      exp_data  = '0;
   endtask

   // One clock edge of the specified behaviour, using the inputs now applied.
   task automatic model_step();
      int            nslot;
      int            last;
      int            s;
      logic [NS-1:0] gnt;
      logic [NS-1:0] rdy;
      cdb_entry_t    e;
      nslot     = 0;
      last      = 0;
      gnt       = '0;
      exp_valid = '0;
      exp_tag   = '0;
      exp_data  = '0;
      for (int j = 0; j < NS; j++) rdy[j] = (mq[j].size() < QD);
      if (flush) begin
         for (int j = 0; j < NS; j++) mq[j].delete();
         rr_m = 0;
         return;
      end
      for (int i = 0; i < NS; i++) begin
         s = (rr_m + i) % NS;
         if (mq[s].size() != 0 && mq[s][0].tag != '0 && nslot < CW) begin
            exp_valid[nslot] = 1'b1;
            exp_tag[nslot]   = mq[s][0].tag;
            exp_data[nslot]  = mq[s][0].data;
            gnt[s]           = 1'b1;
            last             = s;
            nslot++;
         end
      end
      for (int j = 0; j < NS; j++) begin
         if (mq[j].size() != 0 && (gnt[j] || mq[j][0].tag == '0)) void'(mq[j].pop_front());
      end
      for (int j = 0; j < NS; j++) begin
         if (src_valid[j] && rdy[j]) begin
            e.tag  = src_tag[j];
            e.data = src_data[j];
            mq[j].push_back(e);
         end
      end
      if (nslot > 0) rr_m = (last + 1) % NS;
   endtask

   task automatic check_outputs(input string ph);
      logic [NS-1:0] rdy;
      for (int j = 0; j < NS; j++) rdy[j] = (mq[j].size() < QD);
      check_eq({ph, "_valid"}, 64'(cdb_valid), 64'(exp_valid));
      check_eq({ph, "_tags"}, 64'(cdb_tag), 64'(exp_tag));
      for (int k = 0; k < CW; k++)
         check_eq($sformatf("%s_data%0d", ph, k), 64'(cdb_data[k]), 64'(exp_data[k]));
      check_eq({ph, "_ready"}, 64'(src_ready), 64'(rdy));
   endtask

   // Apply inputs just after a falling edge, advance one rising edge, check.
   task automatic cycle(input string ph, input logic [NS-1:0] v, input logic fl);
      src_valid = v;
      flush     = fl;
      model_step();
      @(posedge clk);
      @(negedge clk);
      check_outputs(ph);
   endtask

   task automatic set_src(input int s, input int tag, input logic [31:0] data);
      src_tag[s]  = PB'(tag);
      src_data[s] = data;
   endtask

   initial begin
      logic [NS-1:0] v;
      logic [NS-1:0] rdy;
      rst       = 1'b0;
      flush     = 1'b0;
      src_valid = '0;
      src_tag   = '0;
      src_data  = '0;
      model_clear();

      // Reset state
      #3;
      check_eq("rst_valid", 64'(cdb_valid), 64'd0);
      check_eq("rst_tag", 64'(cdb_tag), 64'd0);
      check_eq("rst_data0", 64'(cdb_data[0]), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check_eq("rst_ready", 64'(src_ready), 64'h3f);
      @(negedge clk);

      // Single result: two-cycle latency, one-cycle broadcast
      set_src(0, 5, 32'hDEADBEEF);
      cycle("single_e1", 6'b000001, 1'b0);
      check_eq("single_e1_v", 64'(cdb_valid), 64'd0);
      cycle("single_e2", 6'b000000, 1'b0);
      check_eq("single_e2_v", 64'(cdb_valid), 64'b0001);
      check_eq("single_e2_tag", 64'(cdb_tag[0]), 64'd5);
      check_eq("single_e2_data", 64'(cdb_data[0]), 64'hDEADBEEF);
      cycle("single_e3", 6'b000000, 1'b0);
      check_eq("single_e3_v", 64'(cdb_valid), 64'd0);
      cycle("rr_clear", 6'b000000, 1'b1);

      // Oversubscription: six results, four slots
      for (int s = 0; s < NS; s++) set_src(s, s + 1, 32'h1000 + s);
      cycle("over_push", 6'b111111, 1'b0);
      cycle("over_b1", 6'b000000, 1'b0);
      check_eq("over_b1_v", 64'(cdb_valid), 64'b1111);
      check_eq("over_b1_tag", 64'(cdb_tag), 64'({6'd4, 6'd3, 6'd2, 6'd1}));
      cycle("over_b2", 6'b000000, 1'b0);
      check_eq("over_b2_v", 64'(cdb_valid), 64'b0011);
      check_eq("over_b2_tag", 64'(cdb_tag), 64'({6'd0, 6'd0, 6'd6, 6'd5}));
      for (int s = 0; s < NS; s++) set_src(s, s + 11, 32'h2000 + s);
      cycle("over_push2", 6'b111111, 1'b0);
      cycle("over_b3", 6'b000000, 1'b0);
      check_eq("over_rr0_tag", 64'(cdb_tag[0]), 64'd11);
      cycle("over_b4", 6'b000000, 1'b0);

      // Tag 0 is dropped without a slot
      set_src(1, 0, 32'h0BAD);
      cycle("tag0_a", 6'b000010, 1'b0);
      set_src(1, 3, 32'h3333);
      cycle("tag0_b", 6'b000010, 1'b0);
      check_eq("tag0_none", 64'(cdb_valid), 64'd0);
      cycle("tag0_c", 6'b000000, 1'b0);
      check_eq("tag0_t3_v", 64'(cdb_valid), 64'b0001);
      check_eq("tag0_t3_tag", 64'(cdb_tag[0]), 64'd3);

      // Backpressure: sustained pushes fill the two ungranted FIFOs
      for (int s = 0; s < NS; s++) set_src(s, 40 + s, 32'h4000 + s);
      cycle("bp_1", 6'b111111, 1'b0);
      cycle("bp_2", 6'b111111, 1'b0);
      check_eq("bp_notready", 64'($countones(~src_ready)), 64'd2);
      for (int i = 0; i < 4; i++) cycle("bp_drain", 6'b000000, 1'b0);

      // Flush with entries buffered and a same-edge push
      for (int s = 0; s < NS; s++) set_src(s, 20 + s, 32'h5000 + s);
      cycle("fl_fill1", 6'b111111, 1'b0);
      cycle("fl_fill2", 6'b111111, 1'b0);
      set_src(0, 9, 32'h9999);
      cycle("fl_edge", 6'b000001, 1'b1);
      check_eq("fl_valid", 64'(cdb_valid), 64'd0);
      check_eq("fl_ready", 64'(src_ready), 64'h3f);
      for (int i = 0; i < 3; i++) begin
         cycle("fl_after", 6'b000000, 1'b0);
         check_eq("fl_after_v", 64'(cdb_valid), 64'd0);
      end

      // Asynchronous reset during a full broadcast
      for (int s = 0; s < NS; s++) set_src(s, 30 + s, 32'h6000 + s);
      cycle("ar_push", 6'b111111, 1'b0);
      cycle("ar_bcast", 6'b000000, 1'b0);
      check_eq("ar_full", 64'(cdb_valid), 64'b1111);
      #2;
      rst = 1'b0;
      #1;
      check_eq("ar_valid", 64'(cdb_valid), 64'd0);
      check_eq("ar_tag", 64'(cdb_tag), 64'd0);
      check_eq("ar_data3", 64'(cdb_data[3]), 64'd0);
      model_clear();
      @(negedge clk);
      rst = 1'b1;
      set_src(0, 12, 32'hC0DE);
      cycle("ar_push12", 6'b000001, 1'b0);
      check_eq("ar_12_early", 64'(cdb_valid), 64'd0);
      cycle("ar_12", 6'b000000, 1'b0);
      check_eq("ar_12_v", 64'(cdb_valid), 64'b0001);
      check_eq("ar_12_tag", 64'(cdb_tag[0]), 64'd12);

      // Randomized traffic; a refused offer is held until accepted
      v = '0;
      for (int n = 0; n < 600; n++) begin
         for (int j = 0; j < NS; j++) rdy[j] = (mq[j].size() < QD);
         for (int s = 0; s < NS; s++) begin
            if (!(v[s] && !rdy[s])) begin
               v[s] = ($urandom_range(0, 9) < 6);
               set_src(s, ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 63)), $urandom);
            end
         end
         cycle("rand", v, ($urandom_range(0, 49) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
